// File: rtl/cfg_chain_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cfg_chain_pkg : shared ops, FSM states and chain length           |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package cfg_chain_pkg;

  localparam int CFG_CHAIN_N = 32;

  localparam logic OP_WRITE    = 1'b0;
  localparam logic OP_READBACK = 1'b1;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_WR = 3'd1,
    CAPTURE  = 3'd2,
    SHIFT_RD = 3'd3,
    RSP      = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/cfg_chain_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cfg_chain_ctrl_if : command/response port plus chain control pins |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface cfg_chain_ctrl_if #(
  parameter int N = cfg_chain_pkg::CFG_CHAIN_N
);
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [N-1:0] cmd_data;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         sr_s_in;
  logic         sr_s_out;
  logic         sr_load;
  logic         sr_read;

  // slave: the controller; master: command source plus the chain it drives
  modport slave (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, sr_s_out,
    output cmd_ready, rsp_valid, rsp_data, sr_s_in, sr_load, sr_read
  );
  modport master (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, sr_s_out,
    input  cmd_ready, rsp_valid, rsp_data, sr_s_in, sr_load, sr_read
  );
endinterface
`default_nettype wire

// File: rtl/cfg_chain_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cfg_chain_ctrl : serial config-chain sequencer (write / readback)  |
// | Readback enabled by defining CFG_READBACK_EN.   Rev 1.0           |
// +------------------------------------------------------------------+
module cfg_chain_ctrl
  import cfg_chain_pkg::*;
#(
  parameter int N = CFG_CHAIN_N
) (
  input  wire logic       clk,
  input  wire logic       reset,
  cfg_chain_ctrl_if.slave bus
);

  localparam int              CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   c_last = CW'(N - 1);

  state_t         r_state;
  state_t         w_next;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_shadow;
  logic           w_last;
  logic           w_cmd_ready;
  logic           w_rsp_valid;
  logic           w_s_in;
  logic           w_load;
  logic           w_read;
  logic           w_wr_accept;

  assign w_last = (r_cnt == c_last);

`ifdef CFG_READBACK_EN
  logic [N-1:0] r_rsp;
  assign w_wr_accept = (r_state == IDLE) && bus.cmd_valid && (bus.cmd_op == OP_WRITE);
`else
  logic w_unused;
  assign w_unused    = ^{bus.cmd_op, bus.rsp_ready, bus.sr_s_out};
  assign w_wr_accept = (r_state == IDLE) && bus.cmd_valid;
`endif

  always_comb begin
    w_next      = r_state;
    w_cmd_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_s_in      = 1'b0;
    w_load      = 1'b1;
    w_read      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
`ifdef CFG_READBACK_EN
          w_next = (bus.cmd_op == OP_READBACK) ? CAPTURE : SHIFT_WR;
`else
          w_next = SHIFT_WR;
`endif
        end
      end
      SHIFT_WR: begin
        w_load = 1'b0;
        w_s_in = r_shadow[r_cnt];
        if (w_last) w_next = IDLE;
      end
`ifdef CFG_READBACK_EN
      CAPTURE: begin
        w_load = 1'b0;
        w_read = 1'b1;
        w_next = SHIFT_RD;
      end
      // Refilling with the shadow leaves the chain holding the committed word
      SHIFT_RD: begin
        w_load = 1'b0;
        w_s_in = r_shadow[r_cnt];
        if (w_last) w_next = RSP;
      end
      RSP: begin
        w_rsp_valid = 1'b1;
        if (bus.rsp_ready) w_next = IDLE;
      end
`endif
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_shadow <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) r_cnt <= '0;
      else if (!w_last)      r_cnt <= r_cnt + CW'(1);
      if (w_wr_accept) r_shadow <= bus.cmd_data;
    end
  end

`ifdef CFG_READBACK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp <= '0;
    end else if (r_state == SHIFT_RD) begin
      r_rsp[r_cnt] <= bus.sr_s_out;
    end
  end
  assign bus.rsp_data = r_rsp;
  assign bus.sr_read  = w_read;
`else
  assign bus.rsp_data = '0;
  assign bus.sr_read  = 1'b0;
`endif

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.sr_s_in   = w_s_in;
  assign bus.sr_load   = w_load;

endmodule
`default_nettype wire

// File: tb/tb_cfg_chain_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cfg_chain_ctrl : scoreboard bench with a behavioural chain      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_cfg_chain_ctrl;
  import cfg_chain_pkg::*;

  localparam int N = CFG_CHAIN_N;

  logic clk = 1'b0;
  logic reset = 1'b1;
  cfg_chain_ctrl_if #(.N(N)) bus ();

  cfg_chain_ctrl #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural downstream chain: s_out is bit 0, shifts toward bit 0
  logic [N-1:0] ch_reg, ch_load, ch_read;
  always @(posedge clk) begin
    if (reset) begin
      ch_reg  <= '0;
      ch_load <= '0;
    end else if (bus.sr_load) ch_load <= ch_reg;
    else if (bus.sr_read)     ch_reg  <= ch_read;
    else                      ch_reg  <= {bus.sr_s_in, ch_reg[N-1:1]};
  end
  assign bus.sr_s_out = ch_reg[0];

  int n_cmp = 0;
  int n_bad = 0;
  int cycle = 0;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    logic         is_rd;
    logic [N-1:0] shifted;
    logic [N-1:0] load_after;
    logic [N-1:0] rsp;
  } exp_t;
  exp_t sb[$];

  // ---------------- monitor ----------------
  bit           prev_ready;
  int           busy, shift_cnt, cap_cnt, first_idx;
  logic [N-1:0] shift_word, rsp_ref, reg_ref, hs_data, hs_reg, hs_load, pend_val;
  bit           rsp_seen, stable, pend;

  task automatic clear_run();
    busy = 0; shift_cnt = 0; cap_cnt = 0; first_idx = 0;
    shift_word = '0; rsp_seen = 0; stable = 1;
    hs_data = '0; hs_reg = '0; hs_load = '0;
  endtask

  always @(negedge clk) begin
    #1;
    if (reset) begin
      clear_run();
      prev_ready = 1;
      pend = 0;
    end else begin
      if (pend) begin
        check("commit_load", ch_load, pend_val);
        pend = 0;
      end
      if (!bus.cmd_ready) begin
        busy++;
        if (!bus.sr_load && !bus.sr_read) begin
          if (shift_cnt < N) shift_word[shift_cnt] = bus.sr_s_in;
          shift_cnt++;
        end
        if (bus.sr_read) cap_cnt++;
        if (bus.rsp_valid) begin
          if (!rsp_seen) begin
            first_idx = busy; rsp_ref = bus.rsp_data; reg_ref = ch_reg;
          end else if (bus.rsp_data !== rsp_ref || bus.sr_load !== 1'b1 || ch_reg !== reg_ref) begin
            stable = 0;
          end
          rsp_seen = 1;
          if (bus.rsp_ready) begin
            hs_data = bus.rsp_data; hs_reg = ch_reg; hs_load = ch_load;
          end
        end
      end else if (!prev_ready) begin
        if (sb.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_op: got op end with empty scoreboard at cycle %0d", cycle);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("shift_count", N'(shift_cnt), N'(N));
          check("shifted_bits", shift_word, e.shifted);
          if (e.is_rd) begin
            check("capture_count", N'(cap_cnt), N'(1));
            check("rsp_latency", N'(first_idx), N'(N + 2));
            check("rsp_data", hs_data, e.rsp);
            check("rsp_stall_stable", N'(stable), N'(1));
            check("chain_restored", hs_reg, e.shifted);
            check("load_kept", hs_load, e.load_after);
          end else begin
            check("write_busy_len", N'(busy), N'(N));
            check("write_no_rsp", N'(rsp_seen), N'(0));
            pend = 1;
            pend_val = e.load_after;
          end
        end
        clear_run();
      end
      prev_ready = bus.cmd_ready;
    end
  end

  // ---------------- driver ----------------
  task automatic do_cmd(input logic op, input logic [N-1:0] data, input bit push,
                        input exp_t e, output int acc);
    acc = -1;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = data;
    for (int i = 0; i < 200 && !bus.cmd_ready; i++) @(negedge clk);
    if (!bus.cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got cmd_ready=0 expected 1 within 200 cycles");
    end else begin
      if (push) sb.push_back(e);
      acc = cycle;
      @(posedge clk);
    end
  endtask

  task automatic drop_valid();
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && !bus.cmd_ready; i++) @(negedge clk);
    if (!bus.cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got cmd_ready=0 expected 1 within 200 cycles");
    end
  endtask

  task automatic wr_exp(input logic [N-1:0] d, output exp_t e);
    e.is_rd = 1'b0; e.shifted = d; e.load_after = d; e.rsp = '0;
  endtask

  initial begin
    exp_t e;
    int   a1, a2;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_WRITE;
    bus.cmd_data  = '0;
    bus.rsp_ready = 1'b0;
    ch_read       = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", N'(bus.cmd_ready), N'(1));
    check("rst_rsp_valid", N'(bus.rsp_valid), N'(0));
    check("rst_rsp_data",  bus.rsp_data, '0);
    check("rst_sr_load",   N'(bus.sr_load), N'(1));
    check("rst_sr_read",   N'(bus.sr_read), N'(0));
    check("rst_sr_s_in",   N'(bus.sr_s_in), N'(0));

    wr_exp(32'hA5C3_0F01, e);
    do_cmd(OP_WRITE, 32'hA5C3_0F01, 1, e, a1);
    drop_valid();
    wait_idle();

    wr_exp(32'h0000_0001, e);
    do_cmd(OP_WRITE, 32'h0000_0001, 1, e, a1);
    wr_exp(32'hFFFF_FFFF, e);
    do_cmd(OP_WRITE, 32'hFFFF_FFFF, 1, e, a2);
    drop_valid();
    wait_idle();
    check("b2b_spacing", N'(a2 - a1), N'(N + 1));

`ifdef CFG_READBACK_EN
    wr_exp(32'hDEAD_BEEF, e);
    do_cmd(OP_WRITE, 32'hDEAD_BEEF, 1, e, a1);
    drop_valid();
    wait_idle();
    ch_read = 32'h1234_5678;
    e.is_rd = 1'b1; e.shifted = 32'hDEAD_BEEF; e.load_after = 32'hDEAD_BEEF; e.rsp = 32'h1234_5678;
    do_cmd(OP_READBACK, 32'h5555_5555, 1, e, a1);
    drop_valid();
    for (int i = 0; i < 200 && !bus.rsp_valid; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    wait_idle();

    ch_read = 32'hCAFE_F00D;
    bus.rsp_ready = 1'b1;
    e.rsp = 32'hCAFE_F00D;
    do_cmd(OP_READBACK, 32'h0, 1, e, a1);
    drop_valid();
    wait_idle();
    bus.rsp_ready = 1'b0;
`endif

    // Reset lands during shift cycle k=10 of a write
    wr_exp(32'h1357_9BDF, e);
    do_cmd(OP_WRITE, 32'h1357_9BDF, 0, e, a1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("abort_in_shift", N'(bus.sr_load), N'(0));
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("abort_idle",      N'(bus.cmd_ready), N'(1));
    check("abort_r_load",    ch_load, '0);
    check("abort_rsp_valid", N'(bus.rsp_valid), N'(0));
    check("abort_sr_load",   N'(bus.sr_load), N'(1));

`ifdef CFG_READBACK_EN
    ch_read = 32'h0BAD_F00D;
    bus.rsp_ready = 1'b1;
    e.is_rd = 1'b1; e.shifted = '0; e.load_after = '0; e.rsp = 32'h0BAD_F00D;
    do_cmd(OP_READBACK, 32'hFFFF_FFFF, 1, e, a1);
    drop_valid();
    wait_idle();
    bus.rsp_ready = 1'b0;
`else
    // Without readback support an op=1 command is an ordinary write
    bus.rsp_ready = 1'b1;
    wr_exp(32'h0000_00FF, e);
    do_cmd(OP_READBACK, 32'h0000_00FF, 1, e, a1);
    drop_valid();
    wait_idle();
    bus.rsp_ready = 1'b0;
`endif

    repeat (5) @(negedge clk);
    check("sb_drained", N'(sb.size()), N'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #50000;
    n_cmp++; n_bad++;
    $display("FAIL watchdog: got no completion expected finish before 5000 cycles");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
